// File: rtl/galapagos_to_axis_bridge.sv
// Galapagos ingress to AXI-Stream bridge: forwards beats addressed to this core, drops the rest.
// Optional byte masking by TKEEP is enabled with `define GP_BRIDGE_TKEEP_MASK_EN.
module galapagos_to_axis_bridge #(
    parameter int unsigned GALAPAGOS_DATA_WIDTH    = 32,
    parameter int unsigned GALAPAGOS_NUM_TRANSFERS = 2,
    parameter int unsigned GALAPAGOS_TID           = 4,
    parameter int unsigned AXI_STREAM_DATA_WIDTH   = 16
) (
    input  logic                               i_clk,
    input  logic                               i_aresetn,
    input  logic [31:0]                        i_core_TID,
    input  logic                               i_gp_TVALID,
    output logic                               o_gp_TREADY,
    input  logic [GALAPAGOS_DATA_WIDTH-1:0]    i_gp_TDATA,
    input  logic [GALAPAGOS_DATA_WIDTH/8-1:0]  i_gp_TKEEP,
    input  logic [7:0]                         i_gp_TDEST,
    input  logic [7:0]                         i_gp_TID,
    input  logic                               i_gp_TLAST,
    output logic                               o_axis_TVALID,
    input  logic                               i_axis_TREADY,
    output logic [AXI_STREAM_DATA_WIDTH-1:0]   o_axis_TDATA
);

    localparam int unsigned KEEP_W = GALAPAGOS_DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = (GALAPAGOS_NUM_TRANSFERS < 1) ? 1 :
                                     $clog2(GALAPAGOS_NUM_TRANSFERS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GALAPAGOS_NUM_TRANSFERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                beat_cnt_q, beat_cnt_d;
    logic                            axis_valid_q, axis_valid_d;
    logic [AXI_STREAM_DATA_WIDTH-1:0] axis_data_q, axis_data_d;

    logic [7:0]                      eff_id;
    logic                            dest_match;
    logic                            gp_hs;
    logic                            axis_hs;
    logic                            fwd_beat;
    logic                            emit;
    logic [GALAPAGOS_DATA_WIDTH-1:0] masked_data;
    logic                            unused_bits;

    // All-ones core TID means "not configured": fall back to the build-time identity
    assign eff_id     = (i_core_TID == 32'hFFFF_FFFF) ? 8'(GALAPAGOS_TID) : i_core_TID[7:0];
    assign dest_match = (i_gp_TDEST == eff_id);

`ifdef GP_BRIDGE_TKEEP_MASK_EN
    for (genvar k = 0; k < KEEP_W; k++) begin : g_mask
        assign masked_data[8*k +: 8] = i_gp_TKEEP[k] ? i_gp_TDATA[8*k +: 8] : 8'h00;
    end
`else
    assign masked_data = i_gp_TDATA;
`endif

    assign unused_bits = ^{i_gp_TID, i_gp_TKEEP, masked_data};

    // Drop mode never stalls; otherwise accept only when the output slot is free or draining
    assign o_gp_TREADY = !i_aresetn &&
                         ((state_q == ST_DROP) || !axis_valid_q || i_axis_TREADY);

    assign gp_hs    = i_gp_TVALID && o_gp_TREADY;
    assign axis_hs  = axis_valid_q && i_axis_TREADY;
    assign fwd_beat = (state_q == ST_FWD) || ((state_q == ST_IDLE) && dest_match);
    assign emit     = gp_hs && fwd_beat && (beat_cnt_q < CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_aresetn) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            axis_valid_q <= 1'b0;
            axis_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            axis_valid_q <= axis_valid_d;
            axis_data_q  <= axis_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        axis_valid_d = axis_valid_q;
        axis_data_d  = axis_data_q;

        if (gp_hs) begin
            case (state_q)
                ST_IDLE: begin
                    if (!i_gp_TLAST) begin
                        state_d = dest_match ? ST_FWD : ST_DROP;
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (i_gp_TLAST) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Saturate so over-long packets cannot wrap back into the forwarding window
            if (i_gp_TLAST) begin
                beat_cnt_d = '0;
            end else if (beat_cnt_q != CNT_MAX) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end

        if (emit) begin
            axis_valid_d = 1'b1;
            axis_data_d  = masked_data[AXI_STREAM_DATA_WIDTH-1:0];
        end else if (axis_hs) begin
            axis_valid_d = 1'b0;
        end
    end

    assign o_axis_TVALID = axis_valid_q;
    assign o_axis_TDATA  = axis_data_q;

endmodule

// File: tb/tb_galapagos_to_axis_bridge.sv
// Randomized bench for galapagos_to_axis_bridge against a packet-level reference model.
module tb_galapagos_to_axis_bridge;

    logic        i_clk = 1'b0;
    logic        i_aresetn;
    logic [31:0] i_core_TID;
    logic        i_gp_TVALID;
    logic        o_gp_TREADY;
    logic [31:0] i_gp_TDATA;
    logic [3:0]  i_gp_TKEEP;
    logic [7:0]  i_gp_TDEST;
    logic [7:0]  i_gp_TID;
    logic        i_gp_TLAST;
    logic        o_axis_TVALID;
    logic        i_axis_TREADY;
    logic [15:0] o_axis_TDATA;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          sink_mode = 2;
    logic [15:0] exp_q [$];
    logic [31:0] pkt_d [8];
    logic [3:0]  pkt_k [8];
    logic        stall_prev = 1'b0;
    logic [15:0] stall_data = 16'h0;

`ifdef GP_BRIDGE_TKEEP_MASK_EN
    localparam logic [15:0] SECOND_WORD = 16'h00FF;
`else
    localparam logic [15:0] SECOND_WORD = 16'hFFFF;
`endif

    galapagos_to_axis_bridge #(
        .GALAPAGOS_DATA_WIDTH   (32),
        .GALAPAGOS_NUM_TRANSFERS(2),
        .GALAPAGOS_TID          (4),
        .AXI_STREAM_DATA_WIDTH  (16)
    ) dut (
        .i_clk        (i_clk),
        .i_aresetn    (i_aresetn),
        .i_core_TID   (i_core_TID),
        .i_gp_TVALID  (i_gp_TVALID),
        .o_gp_TREADY  (o_gp_TREADY),
        .i_gp_TDATA   (i_gp_TDATA),
        .i_gp_TKEEP   (i_gp_TKEEP),
        .i_gp_TDEST   (i_gp_TDEST),
        .i_gp_TID     (i_gp_TID),
        .i_gp_TLAST   (i_gp_TLAST),
        .o_axis_TVALID(o_axis_TVALID),
        .i_axis_TREADY(i_axis_TREADY),
        .o_axis_TDATA (o_axis_TDATA)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic finish_sim();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    // Reference: a beat's output word is its kept bytes, truncated to 16 bits
    function automatic logic [15:0] ref_word(input logic [31:0] d, input logic [3:0] k);
        logic [31:0] m;
        m = d;
`ifdef GP_BRIDGE_TKEEP_MASK_EN
        for (int b = 0; b < 4; b++) begin
            if (!k[b]) m[8*b +: 8] = 8'h00;
        end
`endif
        return m[15:0];
    endfunction

    function automatic logic [7:0] ref_eff_id(input logic [31:0] tid);
        return (tid == 32'hFFFF_FFFF) ? 8'd4 : tid[7:0];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Packets addressed to us contribute their first two beats, others nothing
    task automatic push_model(input logic [7:0] dest, input int len);
        if (dest == ref_eff_id(i_core_TID)) begin
            for (int b = 0; b < len && b < 2; b++) exp_q.push_back(ref_word(pkt_d[b], pkt_k[b]));
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic [7:0] dest,
                             input logic last, input bit chk_rdy, input bit gaps);
        int waited;
        i_gp_TVALID = 1'b1;
        i_gp_TDATA  = d;
        i_gp_TKEEP  = k;
        i_gp_TDEST  = dest;
        i_gp_TID    = 8'($urandom);
        i_gp_TLAST  = last;
        waited = 0;
        @(negedge i_clk);
        if (chk_rdy) check_val("drop_tready", o_gp_TREADY, 1);
        while (!o_gp_TREADY) begin
            waited++;
            if (waited > 200) begin
                check_val("gp_accept_timeout", waited, 0);
                finish_sim();
            end
            @(negedge i_clk);
        end
        @(posedge i_clk);
        #1;
        i_gp_TVALID = 1'b0;
        if (gaps) step($urandom_range(0, 2));
    endtask

    task automatic send_pkt(input logic [7:0] dest, input int len, input bit chk_rdy, input bit gaps);
        push_model(dest, len);
        for (int b = 0; b < len; b++) send_beat(pkt_d[b], pkt_k[b], dest, b == len - 1, chk_rdy, gaps);
    endtask

    task automatic drain();
        int t;
        sink_mode = 2;
        t = 0;
        while ((exp_q.size() != 0 || o_axis_TVALID) && t < 200) begin
            step(1);
            t++;
        end
        if (t >= 200) check_val("drain_timeout", exp_q.size(), 0);
    endtask

    // Output sink: random, held low, or held high
    initial begin
        i_axis_TREADY = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (sink_mode)
                0:       i_axis_TREADY = ($urandom_range(0, 3) != 0);
                1:       i_axis_TREADY = 1'b0;
                default: i_axis_TREADY = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard on each handshake plus hold-stable checks while stalled
    always @(negedge i_clk) begin
        if (!i_aresetn) begin
            if (stall_prev) begin
                check_val("hold_valid", o_axis_TVALID, 1);
                check_val("hold_data", o_axis_TDATA, stall_data);
            end
            if (o_axis_TVALID && i_axis_TREADY) begin
                n_out++;
                check_val("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_val("axis_word", o_axis_TDATA, exp_q.pop_front());
            end
            stall_prev = o_axis_TVALID && !i_axis_TREADY;
            stall_data = o_axis_TDATA;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        int base;
        int t;
        logic [31:0] tids [3];
        i_aresetn   = 1'b1;
        i_core_TID  = 32'h0000_0004;
        i_gp_TVALID = 1'b0;
        i_gp_TDATA  = '0;
        i_gp_TKEEP  = '0;
        i_gp_TDEST  = '0;
        i_gp_TID    = '0;
        i_gp_TLAST  = 1'b0;
        step(3);
        @(negedge i_clk);
        check_val("rst_tvalid", o_axis_TVALID, 0);
        check_val("rst_tdata", o_axis_TDATA, 0);
        check_val("rst_gp_tready", o_gp_TREADY, 0);
        step(1);
        i_aresetn = 1'b0;
        step(1);

        // Directed: two-beat matched packet
        pkt_d[0] = 32'hABCD_EFAB; pkt_k[0] = 4'hF;
        pkt_d[1] = 32'hFFFF_FFFF; pkt_k[1] = 4'h1;
        push_model(8'd4, 2);
        send_beat(pkt_d[0], pkt_k[0], 8'd4, 1'b0, 1'b0, 1'b0);
        check_val("latency_valid", o_axis_TVALID, 1);
        check_val("first_word", o_axis_TDATA, 32'h0000_EFAB);
        send_beat(pkt_d[1], pkt_k[1], 8'd4, 1'b1, 1'b0, 1'b0);
        check_val("second_word", o_axis_TDATA, SECOND_WORD);

        // Mismatched packet is swallowed, the next matched one still forwards
        drain();
        pkt_d[0] = 32'h1111_2222; pkt_k[0] = 4'hF;
        pkt_d[1] = 32'h3333_4444; pkt_k[1] = 4'hF;
        send_pkt(8'd5, 2, 1'b1, 1'b0);
        check_val("drop_no_valid", o_axis_TVALID, 0);
        pkt_d[0] = 32'h5555_6666;
        send_pkt(8'd4, 1, 1'b0, 1'b0);
        check_val("after_drop_fwd", o_axis_TVALID, 1);

        // Three-beat packet forwards only two words
        drain();
        base = n_out;
        pkt_d[0] = 32'hA0A0_0001; pkt_k[0] = 4'hF;
        pkt_d[1] = 32'hA0A0_0002; pkt_k[1] = 4'h3;
        pkt_d[2] = 32'hA0A0_0003; pkt_k[2] = 4'hF;
        send_pkt(8'd4, 3, 1'b0, 1'b0);
        drain();
        check_val("three_beat_words", n_out - base, 2);

        // Output stalled for five cycles with a second beat waiting
        base = n_out;
        sink_mode = 1;
        step(1);
        pkt_d[0] = 32'hABCD_EFAB; pkt_k[0] = 4'hF;
        pkt_d[1] = 32'h1357_9BDF; pkt_k[1] = 4'hF;
        fork
            send_pkt(8'd4, 2, 1'b0, 1'b0);
            begin
                t = 0;
                @(negedge i_clk);
                while (!o_axis_TVALID && t < 50) begin
                    @(negedge i_clk);
                    t++;
                end
                check_val("stall_valid", o_axis_TVALID, 1);
                repeat (5) begin
                    check_val("stall_tdata", o_axis_TDATA, 32'h0000_EFAB);
                    check_val("stall_gp_tready", o_gp_TREADY, 0);
                    @(negedge i_clk);
                end
                sink_mode = 2;
            end
        join
        drain();
        check_val("stall_words", n_out - base, 2);

        // Reset while a word is pending
        sink_mode = 1;
        step(1);
        send_beat(32'h1234_5678, 4'hF, 8'd4, 1'b0, 1'b0, 1'b0);
        check_val("pre_rst_valid", o_axis_TVALID, 1);
        i_aresetn = 1'b1;
        step(1);
        check_val("mid_rst_tvalid", o_axis_TVALID, 0);
        check_val("mid_rst_tdata", o_axis_TDATA, 0);
        check_val("mid_rst_gp_tready", o_gp_TREADY, 0);
        i_aresetn = 1'b0;
        sink_mode = 2;
        step(1);
        base = n_out;
        pkt_d[0] = 32'hCAFE_BEEF; pkt_k[0] = 4'hF;
        pkt_d[1] = 32'hDEAD_0F0F; pkt_k[1] = 4'hE;
        send_pkt(8'd4, 2, 1'b0, 1'b0);
        drain();
        check_val("post_rst_words", n_out - base, 2);

        // Random packets, identities and backpressure
        tids[0] = 32'hFFFF_FFFF;
        tids[1] = 32'h0000_0004;
        tids[2] = 32'h1234_5609;
        for (int p = 0; p < 80; p++) begin
            int          len;
            logic [7:0]  dest;
            i_core_TID = tids[$urandom_range(0, 2)];
            sink_mode  = ($urandom_range(0, 3) == 0) ? 2 : 0;
            len        = $urandom_range(1, 5);
            dest       = ($urandom_range(0, 1) == 0) ? ref_eff_id(i_core_TID) : 8'($urandom);
            for (int b = 0; b < len; b++) begin
                pkt_d[b] = $urandom;
                pkt_k[b] = 4'($urandom);
            end
            send_pkt(dest, len, 1'b0, 1'b1);
        end

        drain();
        check_val("leftover_words", exp_q.size(), 0);
        finish_sim();
    end

endmodule
